pms_top: RTL and testbench

// - Reduced PMS top-level: boot/control CSRs, a 16-word mailbox and a CLIC-style interrupt arbiter,
//   all behind one 32-bit external memory-mapped slave port.
// - Ext irq lines are edge-detected into CLIC pending bits; the highest level/priority pending,

---
 rtl/pms_pkg.sv | 41 ++++
 rtl/pms_top_clic_arbiter.sv | 56 +++++
 rtl/pms_top.sv | 206 ++++++++++++++++++++
 tb/tb_pms_top.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pms_pkg.sv
// Shared definitions for the reduced PMS: address map, bus response codes and
// small helpers for CLIC control fields and byte-enabled register writes.
package pms_pkg;

    localparam int unsigned NumIrqDflt       = 256;
    localparam int unsigned NlBitsDflt       = 4;
    localparam int unsigned ExtIrqOffsetDflt = 30;
    localparam logic [31:0] BootAddrRstDflt  = 32'h1C00_8080;

    localparam logic [31:0] AddrBootmode   = 32'h1A10_4000;
    localparam logic [31:0] AddrBootAddr   = 32'h1A10_4004;
    localparam logic [31:0] AddrFetchEn    = 32'h1A10_4008;
    localparam logic [31:0] AddrUartRxEn   = 32'h1A10_400C;
    localparam logic [31:0] AddrEoc        = 32'h1A10_4010;
    localparam logic [31:0] AddrMboxBase   = 32'h2000_0000;
    localparam logic [31:0] AddrClicCfg    = 32'h1A20_0000;
    localparam logic [31:0] AddrClicThresh = 32'h1A20_0004;
    localparam logic [19:0] ClicIntPage    = 20'h1A201;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespSlvErr = 2'b10
    } resp_t;

    // Level field left-aligned in the ctl byte, unused low bits forced to ones.
    function automatic logic [7:0] ctl_level(input logic [7:0] ctl, input int unsigned nlbits);
        return ctl | (8'hFF >> nlbits);
    endfunction

    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/pms_top_clic_arbiter.sv
// CLIC arbiter: picks the pending, enabled line with the largest ctl byte above
// threshold; ties go to the higher line id. Purely combinational.
module clic_arbiter
    import pms_pkg::*;
#(
    parameter int unsigned NUM_IRQ = NumIrqDflt,
    parameter int unsigned NLBITS  = NlBitsDflt
) (
    input  logic [NUM_IRQ-1:0] ip_i,
    input  logic [NUM_IRQ-1:0] ie_i,
    input  logic [7:0]         ctl_i [NUM_IRQ],
    input  logic [7:0]         thresh_i,
    output logic               valid_o,
    output logic [7:0]         id_o,
    output logic [7:0]         level_o
);

    localparam int unsigned Leaves = 1 << $clog2(NUM_IRQ);
    localparam int unsigned Nodes  = 2 * Leaves - 1;

    logic       node_vld [Nodes];
    logic [7:0] node_key [Nodes];
    logic [7:0] node_id  [Nodes];

    // Heap-ordered tree: leaf i sits at Leaves-1+i, so right subtrees hold higher ids.
    always_comb begin
        for (int n = 0; n < int'(Nodes); n++) begin
            node_vld[n] = 1'b0;
            node_key[n] = '0;
            node_id[n]  = '0;
        end
        for (int i = 0; i < int'(Leaves); i++) begin
            if (i < int'(NUM_IRQ)) begin
                node_vld[Leaves-1+i] = ip_i[i] & ie_i[i] &
                                       (ctl_level(ctl_i[i], NLBITS) > thresh_i);
                node_key[Leaves-1+i] = ctl_i[i];
                node_id[Leaves-1+i]  = 8'(i);
            end
        end
        for (int n = int'(Leaves) - 2; n >= 0; n--) begin
            if (node_vld[2*n+2] && (!node_vld[2*n+1] || node_key[2*n+2] >= node_key[2*n+1])) begin
                node_vld[n] = 1'b1;
                node_key[n] = node_key[2*n+2];
                node_id[n]  = node_id[2*n+2];
            end else begin
                node_vld[n] = node_vld[2*n+1];
                node_key[n] = node_key[2*n+1];
                node_id[n]  = node_id[2*n+1];
            end
        end
        valid_o = node_vld[0];
        id_o    = node_id[0];
        level_o = ctl_level(node_key[0], NLBITS);
    end

endmodule

// File: rtl/pms_top.sv
// Reduced PMS top: boot/control CSRs, 16-word mailbox and CLIC interrupt
// registers behind a single 32-bit slave port with a registered response.
module pms_top
    import pms_pkg::*;
#(
    parameter int unsigned NUM_IRQ        = NumIrqDflt,
    parameter int unsigned NLBITS         = NlBitsDflt,
    parameter int unsigned EXT_IRQ_OFFSET = ExtIrqOffsetDflt,
    parameter logic [31:0] BOOT_ADDR_RST  = BootAddrRstDflt
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         ext_req_i,
    input  logic         ext_we_i,
    input  logic [31:0]  ext_addr_i,
    input  logic [3:0]   ext_be_i,
    input  logic [31:0]  ext_wdata_i,
    output logic         ext_gnt_o,
    output logic         ext_rvalid_o,
    output logic [31:0]  ext_rdata_o,
    output logic [1:0]   ext_resp_o,
    input  logic [255:0] ext_irq_i,
    output logic         irq_valid_o,
    output logic [7:0]   irq_id_o,
    output logic [7:0]   irq_level_o,
    input  logic         irq_ack_i,
    output logic [31:0]  bootmode_o,
    output logic [31:0]  boot_addr_o,
    output logic         fetch_en_o,
    output logic         uart_rx_en_o,
    output logic         eoc_o,
    output logic [30:0]  exit_status_o
);

    logic [31:0]        bootmode_q, bootmode_d, boot_addr_q, boot_addr_d, eoc_q, eoc_d;
    logic               fetch_en_q, fetch_en_d, uart_rx_en_q, uart_rx_en_d;
    logic [31:0]        mbox_q [16];
    logic [31:0]        mbox_d [16];
    logic [7:0]         thresh_q, thresh_d;
    logic [NUM_IRQ-1:0] ip_q, ip_d, ie_q, ie_d, ip_arb, edge_set;
    logic [7:0]         ctl_q [NUM_IRQ];
    logic [7:0]         ctl_d [NUM_IRQ];
    logic [255:0]       irq_prev_q;
    logic               rvalid_q;
    logic [31:0]        rdata_q, rdata_d;
    resp_t              resp_q, resp_d;
    logic               irq_valid_q, arb_valid;
    logic [7:0]         irq_id_q, irq_level_q, arb_id, arb_level;

    logic       wr, hit, sel_int;
    logic [9:0] int_idx;
    logic [7:0] irq_idx;
    logic [31:0] rd;

    assign wr      = ext_req_i & ext_we_i;
    assign int_idx = ext_addr_i[11:2];
    assign irq_idx = int_idx[7:0];
    assign sel_int = (ext_addr_i[31:12] == ClicIntPage) && (ext_addr_i[1:0] == 2'b00) &&
                     (32'(int_idx) < NUM_IRQ);

    always_comb begin
        bootmode_d   = bootmode_q;
        boot_addr_d  = boot_addr_q;
        fetch_en_d   = fetch_en_q;
        uart_rx_en_d = uart_rx_en_q;
        eoc_d        = eoc_q;
        mbox_d       = mbox_q;
        thresh_d     = thresh_q;
        ie_d         = ie_q;
        ctl_d        = ctl_q;
        ip_d         = ip_q;
        hit          = 1'b1;
        rd           = '0;
        if (ext_addr_i == AddrBootmode) begin
            rd = bootmode_q;
            if (wr) bootmode_d = apply_be(bootmode_q, ext_wdata_i, ext_be_i);
        end else if (ext_addr_i == AddrBootAddr) begin
            rd = boot_addr_q;
            if (wr) boot_addr_d = apply_be(boot_addr_q, ext_wdata_i, ext_be_i);
        end else if (ext_addr_i == AddrFetchEn) begin
            rd = {31'b0, fetch_en_q};
            if (wr && ext_be_i[0]) fetch_en_d = ext_wdata_i[0];
        end else if (ext_addr_i == AddrUartRxEn) begin
            rd = {31'b0, uart_rx_en_q};
            if (wr && ext_be_i[0]) uart_rx_en_d = ext_wdata_i[0];
        end else if (ext_addr_i == AddrEoc) begin
            rd = eoc_q;
            if (wr) eoc_d = apply_be(eoc_q, ext_wdata_i, ext_be_i);
        end else if (ext_addr_i[31:6] == AddrMboxBase[31:6] && ext_addr_i[1:0] == 2'b00) begin
            rd = mbox_q[ext_addr_i[5:2]];
            if (wr) mbox_d[ext_addr_i[5:2]] = apply_be(mbox_q[ext_addr_i[5:2]], ext_wdata_i,
                                                       ext_be_i);
        end else if (ext_addr_i == AddrClicCfg) begin
            rd = {27'b0, 4'(NLBITS), 1'b0};
        end else if (ext_addr_i == AddrClicThresh) begin
            rd = {24'b0, thresh_q};
            if (wr && ext_be_i[0]) thresh_d = ext_wdata_i[7:0];
        end else if (sel_int) begin
            rd = {ctl_q[irq_idx], 8'h00, 7'b0, ie_q[irq_idx], 7'b0, ip_q[irq_idx]};
            if (wr && ext_be_i[0]) ip_d[irq_idx] = ext_wdata_i[0];
            if (wr && ext_be_i[1]) ie_d[irq_idx] = ext_wdata_i[8];
            if (wr && ext_be_i[3]) ctl_d[irq_idx] = ext_wdata_i[31:24];
        end else begin
            hit = 1'b0;
        end

        // Unless hit, discard every write staged above.
        if (!ext_req_i || !hit) begin
            bootmode_d   = bootmode_q;
            boot_addr_d  = boot_addr_q;
            fetch_en_d   = fetch_en_q;
            uart_rx_en_d = uart_rx_en_q;
            eoc_d        = eoc_q;
            mbox_d       = mbox_q;
            thresh_d     = thresh_q;
            ie_d         = ie_q;
            ctl_d        = ctl_q;
            ip_d         = ip_q;
        end

        // Pending update order gives edge set > ack clear > software write.
        ip_arb = ip_q;
        if (irq_ack_i && irq_valid_q) begin
            ip_d[irq_id_q]   = 1'b0;
            ip_arb[irq_id_q] = 1'b0;
        end
        edge_set = '0;
        for (int k = 0; k < 256; k++) begin
            if (k + EXT_IRQ_OFFSET < NUM_IRQ) begin
                edge_set[k+EXT_IRQ_OFFSET] = ext_irq_i[k] & ~irq_prev_q[k];
            end
        end
        ip_d = ip_d | edge_set;

        rdata_d = (ext_req_i && !ext_we_i && hit) ? rd : '0;
        resp_d  = (ext_req_i && !hit) ? RespSlvErr : RespOkay;
    end

    clic_arbiter #(
        .NUM_IRQ (NUM_IRQ),
        .NLBITS  (NLBITS)
    ) u_clic_arbiter (
        .ip_i     (ip_arb),
        .ie_i     (ie_q),
        .ctl_i    (ctl_q),
        .thresh_i (thresh_q),
        .valid_o  (arb_valid),
        .id_o     (arb_id),
        .level_o  (arb_level)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bootmode_q   <= '0;
            boot_addr_q  <= BOOT_ADDR_RST;
            fetch_en_q   <= 1'b0;
            uart_rx_en_q <= 1'b0;
            eoc_q        <= '0;
            for (int i = 0; i < 16; i++) mbox_q[i] <= '0;
            thresh_q     <= '0;
            ip_q         <= '0;
            ie_q         <= '0;
            for (int i = 0; i < int'(NUM_IRQ); i++) ctl_q[i] <= '0;
            irq_prev_q   <= '0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            resp_q       <= RespOkay;
            irq_valid_q  <= 1'b0;
            irq_id_q     <= '0;
            irq_level_q  <= '0;
        end else begin
            bootmode_q   <= bootmode_d;
            boot_addr_q  <= boot_addr_d;
            fetch_en_q   <= fetch_en_d;
            uart_rx_en_q <= uart_rx_en_d;
            eoc_q        <= eoc_d;
            mbox_q       <= mbox_d;
            thresh_q     <= thresh_d;
            ip_q         <= ip_d;
            ie_q         <= ie_d;
            ctl_q        <= ctl_d;
            irq_prev_q   <= ext_irq_i;
            rvalid_q     <= ext_req_i;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
            irq_valid_q  <= arb_valid;
            irq_id_q     <= arb_id;
            irq_level_q  <= arb_level;
        end
    end

    assign ext_gnt_o     = ext_req_i;
    assign ext_rvalid_o  = rvalid_q;
    assign ext_rdata_o   = rdata_q;
    assign ext_resp_o    = resp_q;
    assign irq_valid_o   = irq_valid_q;
    assign irq_id_o      = irq_id_q;
    assign irq_level_o   = irq_level_q;
    assign bootmode_o    = bootmode_q;
    assign boot_addr_o   = boot_addr_q;
    assign fetch_en_o    = fetch_en_q;
    assign uart_rx_en_o  = uart_rx_en_q;
    assign eoc_o         = eoc_q[31];
    assign exit_status_o = eoc_q[30:0];

endmodule

// File: tb/tb_pms_top.sv
// Scoreboard bench for pms_top: bus responses are queued at issue and checked
// by a monitor; side-band outputs are checked directly against directed values.
module tb_pms_top;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req = 1'b0, we = 1'b0, ack = 1'b0;
    logic [31:0]  addr = '0, wdata = '0;
    logic [3:0]   be = '0;
    logic [255:0] ext_irq = '0;
    logic         gnt, rvalid, irq_valid, fetch_en, uart_rx_en, eoc;
    logic [31:0]  rdata, bootmode, boot_addr;
    logic [1:0]   resp;
    logic [7:0]   irq_id, irq_level;
    logic [30:0]  exit_status;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;
    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;

    pms_top u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .ext_req_i     (req),
        .ext_we_i      (we),
        .ext_addr_i    (addr),
        .ext_be_i      (be),
        .ext_wdata_i   (wdata),
        .ext_gnt_o     (gnt),
        .ext_rvalid_o  (rvalid),
        .ext_rdata_o   (rdata),
        .ext_resp_o    (resp),
        .ext_irq_i     (ext_irq),
        .irq_valid_o   (irq_valid),
        .irq_id_o      (irq_id),
        .irq_level_o   (irq_level),
        .irq_ack_i     (ack),
        .bootmode_o    (bootmode),
        .boot_addr_o   (boot_addr),
        .fetch_en_o    (fetch_en),
        .uart_rx_en_o  (uart_rx_en),
        .eoc_o         (eoc),
        .exit_status_o (exit_status)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && rvalid) begin
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_rvalid: got rdata %h resp %b, required no response",
                         rdata, resp);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                tests++;
                if (rdata !== e.rdata || resp !== e.resp) begin
                    fails++;
                    $display("FAIL bus_resp@%h: got rdata %h resp %b, required rdata %h resp %b",
                             e.addr, rdata, resp, e.rdata, e.resp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [31:0] exp_rd, input logic [1:0] exp_rs);
        exp_t e;
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        e.addr = a; e.rdata = exp_rd; e.resp = exp_rs;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        check("rst_boot_addr", boot_addr, 32'h1C00_8080);
        check("rst_fetch_en", {31'b0, fetch_en}, 32'd0);
        check("rst_eoc", {31'b0, eoc}, 32'd0);
        check("rst_irq_valid", {31'b0, irq_valid}, 32'd0);
        rst_n = 1'b1;
        cyc();
        bus(1'b0, 32'h2000_0000, 0, 4'h0, 32'h0, 2'b00);

        // CSRs
        req = 1'b1; #0;
        check("gnt_comb", {31'b0, gnt}, 32'd1);
        bus(1'b1, 32'h1A10_4000, 32'd3, 4'hF, 0, 2'b00);
        bus(1'b1, 32'h1A10_4004, 32'h1C00_8080, 4'hF, 0, 2'b00);
        bus(1'b1, 32'h1A10_4008, 32'd1, 4'hF, 0, 2'b00);
        check("bootmode", bootmode, 32'd3);
        check("fetch_en", {31'b0, fetch_en}, 32'd1);
        bus(1'b0, 32'h1A10_4000, 0, 4'h0, 32'd3, 2'b00);
        bus(1'b0, 32'h1A10_4004, 0, 4'h0, 32'h1C00_8080, 2'b00);

        // Mailbox, byte enables, error decode, read-only regs
        bus(1'b1, 32'h2000_0000, 32'd1, 4'hF, 0, 2'b00);
        bus(1'b0, 32'h2000_0000, 0, 4'h0, 32'd1, 2'b00);
        bus(1'b1, 32'h2000_003C, 32'hAABB_CCDD, 4'b0101, 0, 2'b00);
        bus(1'b0, 32'h2000_003C, 0, 4'h0, 32'h00BB_00DD, 2'b00);
        bus(1'b0, 32'h1B00_0000, 0, 4'h0, 32'h0, 2'b10);
        bus(1'b1, 32'h1B00_0000, 32'hFFFF_FFFF, 4'hF, 0, 2'b10);
        bus(1'b0, 32'h1A20_1400, 0, 4'h0, 32'h0, 2'b10);
        bus(1'b1, 32'h1A20_0000, 32'hFFFF_FFFF, 4'hF, 0, 2'b00);
        bus(1'b0, 32'h1A20_0000, 0, 4'h0, 32'h0000_0008, 2'b00);

        // Priority ordering by level
        bus(1'b1, 32'h1A20_1078, 32'h0000_0100, 4'b0010, 0, 2'b00);
        bus(1'b1, 32'h1A20_107C, 32'h0000_0100, 4'b0010, 0, 2'b00);
        bus(1'b1, 32'h1A20_1078, 32'h3F00_0000, 4'b1000, 0, 2'b00);
        bus(1'b1, 32'h1A20_107C, 32'h8F00_0000, 4'b1000, 0, 2'b00);
        check("no_irq_before_edge", {31'b0, irq_valid}, 32'd0);
        ext_irq[1:0] = 2'b11; cyc(); ext_irq = '0;
        cyc();
        check("irq_valid_lvl", {31'b0, irq_valid}, 32'd1);
        check("irq_id_lvl", {24'b0, irq_id}, 32'd31);
        check("irq_level_lvl", {24'b0, irq_level}, 32'h8F);
        ack = 1'b1; cyc(); ack = 1'b0;
        check("irq_id_after_ack", {24'b0, irq_id}, 32'd30);
        check("irq_level_after_ack", {24'b0, irq_level}, 32'h3F);
        bus(1'b0, 32'h1A20_107C, 0, 4'h0, 32'h8F00_0100, 2'b00);
        ack = 1'b1; cyc(); ack = 1'b0;
        check("irq_valid_drained", {31'b0, irq_valid}, 32'd0);

        // Equal keys: higher id wins; threshold masks
        bus(1'b1, 32'h1A20_1078, 32'h8000_0000, 4'b1000, 0, 2'b00);
        bus(1'b1, 32'h1A20_107C, 32'h8000_0000, 4'b1000, 0, 2'b00);
        ext_irq[1:0] = 2'b11; cyc(); ext_irq = '0;
        cyc();
        check("tie_id", {24'b0, irq_id}, 32'd31);
        check("tie_level", {24'b0, irq_level}, 32'h8F);
        bus(1'b1, 32'h1A20_0004, 32'h0000_008F, 4'b0001, 0, 2'b00);
        cyc();
        check("thresh_masks", {31'b0, irq_valid}, 32'd0);
        bus(1'b0, 32'h1A20_0004, 0, 4'h0, 32'h0000_008F, 2'b00);
        bus(1'b1, 32'h1A20_0004, 32'h0, 4'b0001, 0, 2'b00);
        cyc();
        check("thresh_open_id", {24'b0, irq_id}, 32'd31);

        // Ack and new edge on the same line in one cycle keeps it pending
        ack = 1'b1; ext_irq[1] = 1'b1; cyc(); ack = 1'b0; ext_irq = '0;
        check("ack_edge_next_id", {24'b0, irq_id}, 32'd30);
        bus(1'b0, 32'h1A20_107C, 0, 4'h0, 32'h8000_0101, 2'b00);
        bus(1'b1, 32'h1A20_1078, 32'h0, 4'b0001, 0, 2'b00);
        bus(1'b0, 32'h1A20_1078, 0, 4'h0, 32'h8000_0100, 2'b00);

        // EOC
        bus(1'b1, 32'h1A10_4010, 32'h8000_0000, 4'hF, 0, 2'b00);
        check("eoc", {31'b0, eoc}, 32'd1);
        check("exit_status", {1'b0, exit_status}, 32'd0);

        // Reset with a response in flight
        req = 1'b1; we = 1'b0; addr = 32'h2000_0000;
        cyc();
        req = 1'b0; rst_n = 1'b0; #1;
        check("rst_kills_rvalid", {31'b0, rvalid}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check("rst2_irq_valid", {31'b0, irq_valid}, 32'd0);
        check("rst2_eoc", {31'b0, eoc}, 32'd0);
        check("rst2_bootmode", bootmode, 32'd0);
        bus(1'b0, 32'h1A20_107C, 0, 4'h0, 32'h0, 2'b00);
        bus(1'b0, 32'h2000_0000, 0, 4'h0, 32'h0, 2'b00);
        cyc(); cyc();

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_responses: got %0d outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
